// File: rtl/n_ms_c2_serial_converter_pkg.sv
// ---------------------------------------------------------------------------
// n_ms_c2_serial_converter_pkg
// Shared definitions for the bit-serial sign-magnitude / two's complement
// family: FSM state encoding, operating-mode encodings and the bit-cell rule.
// ---------------------------------------------------------------------------
package n_ms_c2_serial_converter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic MODE_MS2C2 = 1'b0;  // x_in is a magnitude, sgn_in is the sign
   localparam logic MODE_C22MS = 1'b1;  // x_in is a two's complement value

   // Copy bits up to and including the first 1, invert every bit after it.
   function automatic logic negate_bit(input logic neg, input logic seen_one,
                                       input logic b);
      return (neg & seen_one) ? ~b : b;
   endfunction

endpackage

// File: rtl/n_ms_c2_serial_converter_negator_cell.sv
// ---------------------------------------------------------------------------
// serial_c2_negator_cell
// One-bit serial negation cell, LSB first.
//   clock, reset_ : rising-edge clock, asynchronous active-low reset
//   clear         : restart a new operand (seen_one <= 0)
//   enable        : consume bit b this cycle
//   neg           : 1 = negate the stream, 0 = pass it through
//   b             : current input bit
//   r             : current output bit (combinational)
//   seen_one      : a 1 has already passed through the cell
// ---------------------------------------------------------------------------
module serial_c2_negator_cell
   import n_ms_c2_serial_converter_pkg::*;
(
   input  logic clock,
   input  logic reset_,
   input  logic clear,
   input  logic enable,
   input  logic neg,
   input  logic b,
   output logic r,
   output logic seen_one
);

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         seen_one <= 1'b0;
      end else if (clear) begin
         seen_one <= 1'b0;
      end else if (enable) begin
         seen_one <= seen_one | b;
      end
   end

   // Uses the flag from before this bit, so the first 1 itself is copied.
   assign r = negate_bit(neg, seen_one, b);

endmodule

// File: rtl/n_ms_c2_serial_converter.sv
// ---------------------------------------------------------------------------
// n_ms_c2_serial_converter
// Bit-serial converter between sign-magnitude and two's complement, N bits,
// one bit per clock, LSB first, with valid/ready handshakes on both sides.
//   clock, reset_        : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high only when idle)
//   mode                 : 0 = MS->C2, 1 = C2->MS
//   x_in, sgn_in         : operand and its sign (sign used in MS->C2 only)
//   out_valid / out_ready: result handshake; outputs hold while stalled
//   z_out                : C2 value (mode 0) or magnitude (mode 1)
//   sgn_out              : sign of the result / of the input value
//   ow                   : overflow of the MS->C2 conversion, 0 in mode 1
// ---------------------------------------------------------------------------
module n_ms_c2_serial_converter
   import n_ms_c2_serial_converter_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clock,
   input  logic         reset_,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         mode,
   input  logic [N-1:0] x_in,
   input  logic         sgn_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] z_out,
   output logic         sgn_out,
   output logic         ow
);

   localparam int CW = $clog2(N);

   state_t         state;
   logic [N-1:0]   sr;
   logic [CW-1:0]  cnt;
   logic           neg;
   logic           mode_q;
   logic           ow_q;
   logic           cell_r;
   logic           cell_seen;
   logic           accept;
   logic           neg_in;
   logic           ow_in;
   logic           sgn_in_res;

   assign accept     = (state == ST_IDLE) & in_valid;
   assign neg_in     = (mode == MODE_MS2C2) ? sgn_in : x_in[N-1];
   // -2^(N-1) is the only magnitude with the top bit set that still fits.
   assign ow_in      = (mode == MODE_MS2C2) & x_in[N-1]
                       & ~(sgn_in & (x_in[N-2:0] == '0));
   // Minus zero maps to plain zero, so its sign is dropped.
   assign sgn_in_res = (mode == MODE_MS2C2) ? (neg_in & (x_in != '0)) : x_in[N-1];

   serial_c2_negator_cell u_cell (
      .clock    (clock),
      .reset_   (reset_),
      .clear    (accept),
      .enable   (state == ST_SHIFT),
      .neg      (neg),
      .b        (sr[0]),
      .r        (cell_r),
      .seen_one (cell_seen)
   );

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sr        <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         mode_q    <= MODE_MS2C2;
         ow_q      <= 1'b0;
         sgn_out   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  sr       <= x_in;
                  mode_q   <= mode;
                  neg      <= neg_in;
                  ow_q     <= ow_in;
                  sgn_out  <= sgn_in_res;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // Result bits enter at the top; after N shifts the whole
               // operand has been replaced by the converted value.
               sr  <= {cell_r, sr[N-1:1]};
               cnt <= cnt + CW'(1);
               if (cnt == CW'(N - 1)) begin
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign z_out = sr;
   assign ow    = ow_q & (mode_q == MODE_MS2C2);

endmodule

// File: tb/tb_n_ms_c2_serial_converter.sv
// ---------------------------------------------------------------------------
// tb_n_ms_c2_serial_converter
// Directed bench for the serial MS/C2 converter at N=4 and N=8, plus a full
// operand sweep at N=8 against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_n_ms_c2_serial_converter;

   logic       clk;
   logic       reset_;

   logic       in_valid4, in_ready4, mode4, sgn4, out_valid4, out_ready4, sgn_out4, ow4;
   logic [3:0] x4, z4;
   logic       in_valid8, in_ready8, mode8, sgn8, out_valid8, out_ready8, sgn_out8, ow8;
   logic [7:0] x8, z8;

   int         n_checks;
   int         n_err;
   int         cyc;
   int         lat;
   int         idx, got, guard, last_cyc;
   logic [9:0] exp_q[$];
   logic [9:0] exp_v;

   n_ms_c2_serial_converter #(.N(4)) dut4 (
      .clock(clk), .reset_(reset_), .in_valid(in_valid4), .in_ready(in_ready4),
      .mode(mode4), .x_in(x4), .sgn_in(sgn4), .out_valid(out_valid4),
      .out_ready(out_ready4), .z_out(z4), .sgn_out(sgn_out4), .ow(ow4)
   );

   n_ms_c2_serial_converter #(.N(8)) dut8 (
      .clock(clk), .reset_(reset_), .in_valid(in_valid8), .in_ready(in_ready8),
      .mode(mode8), .x_in(x8), .sgn_in(sgn8), .out_valid(out_valid8),
      .out_ready(out_ready8), .z_out(z8), .sgn_out(sgn_out8), .ow(ow8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: result = arithmetic negation when the value is negative.
   function automatic logic [9:0] model(input logic m, input logic [7:0] x, input logic s);
      logic [7:0] z;
      logic       so, o;
      if (m == 1'b0) begin
         z  = s ? 8'(0 - x) : x;
         so = s & (x != 8'd0);
         o  = x[7] & ~(s & (x[6:0] == 7'd0));
      end else begin
         z  = x[7] ? 8'(0 - x) : x;
         so = x[7];
         o  = 1'b0;
      end
      return {z, so, o};
   endfunction

   // lat = number of edges after the accept edge until out_valid is seen.
   task automatic run4(input logic m, input logic [3:0] x, input logic s, output int l);
      @(negedge clk);
      mode4 = m; x4 = x; sgn4 = s; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      l = 0;
      while (out_valid4 !== 1'b1 && l < 40) begin
         @(posedge clk); #1;
         l++;
      end
   endtask

   task automatic run8(input logic m, input logic [7:0] x, input logic s, output int l);
      @(negedge clk);
      mode8 = m; x8 = x; sgn8 = s; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      l = 0;
      while (out_valid8 !== 1'b1 && l < 40) begin
         @(posedge clk); #1;
         l++;
      end
   endtask

   initial begin
      n_checks = 0; n_err = 0;
      reset_ = 1'b0;
      in_valid4 = 0; mode4 = 0; x4 = '0; sgn4 = 0; out_ready4 = 1'b1;
      in_valid8 = 0; mode8 = 0; x8 = '0; sgn8 = 0; out_ready8 = 1'b1;

      #12;
      check("rst_in_ready4", 32'(in_ready4), 32'd1);
      check("rst_out4", {z4, sgn_out4, ow4, out_valid4}, 32'd0);
      check("rst_in_ready8", 32'(in_ready8), 32'd1);
      check("rst_out8", {z8, sgn_out8, ow8, out_valid8}, 32'd0);
      @(negedge clk);
      reset_ = 1'b1;

      // N=4, MS->C2 of -5; accept edge plus N shift edges = N+1 edges
      run4(1'b0, 4'b0101, 1'b1, lat);
      check("n4_latency", 32'(lat), 32'd4);
      check("n4_m5_z", 32'(z4), 32'b1011);
      check("n4_m5_sgn", 32'(sgn_out4), 32'd1);
      check("n4_m5_ow", 32'(ow4), 32'd0);
      check("n4_m5_in_ready", 32'(in_ready4), 32'd0);
      @(posedge clk); #1;
      check("n4_back_idle", {out_valid4, in_ready4}, 32'b01);

      run4(1'b0, 4'b1000, 1'b1, lat);
      check("n4_m8_z", 32'(z4), 32'b1000);
      check("n4_m8_ow", 32'(ow4), 32'd0);
      @(posedge clk); #1;
      run4(1'b0, 4'b1000, 1'b0, lat);
      check("n4_p8_ow", 32'(ow4), 32'd1);
      @(posedge clk); #1;
      run4(1'b0, 4'b1001, 1'b1, lat);
      check("n4_m9_ow", 32'(ow4), 32'd1);
      @(posedge clk); #1;
      run4(1'b0, 4'b0000, 1'b1, lat);
      check("n4_mzero", {z4, sgn_out4, ow4}, 32'd0);
      @(posedge clk); #1;

      // N=8, C2->MS
      run8(1'b1, 8'hF6, 1'b0, lat);
      check("n8_latency", 32'(lat), 32'd8);
      check("n8_f6", {z8, sgn_out8}, {8'h0A, 1'b1});
      @(posedge clk); #1;
      run8(1'b1, 8'h80, 1'b1, lat);
      check("n8_80", {z8, sgn_out8, ow8}, {8'h80, 1'b1, 1'b0});
      @(posedge clk); #1;
      run8(1'b1, 8'h35, 1'b0, lat);
      check("n8_35", {z8, sgn_out8, ow8}, {8'h35, 1'b0, 1'b0});
      @(posedge clk); #1;

      // N=8, MS->C2 of -42 with the consumer stalling in DONE
      out_ready8 = 1'b0;
      run8(1'b0, 8'h2A, 1'b1, lat);
      check("hold_first", {z8, sgn_out8, ow8}, {8'hD6, 1'b1, 1'b0});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid8 = 1'b1; x8 = 8'h11; mode8 = 1'b1;
         @(posedge clk); #1;
         check("hold_valid", 32'(out_valid8), 32'd1);
         check("hold_z", 32'(z8), 32'hD6);
         check("hold_in_ready", 32'(in_ready8), 32'd0);
      end
      @(negedge clk);
      out_ready8 = 1'b1; in_valid8 = 1'b0;
      @(posedge clk); #1;
      check("hold_release", {out_valid8, in_ready8}, 32'b01);
      check("hold_no_capture", 32'(z8), 32'hD6);

      // Sweep every operand x sign x mode, back to back
      idx = 0; got = 0; guard = 0; last_cyc = -1;
      while (got < 1024 && guard < 15000) begin
         @(negedge clk);
         guard++;
         if (out_valid8 === 1'b1) begin
            if (exp_q.size() > 0) exp_v = exp_q.pop_front();
            else exp_v = 10'h3FF;
            check("sweep", {z8, sgn_out8, ow8}, 32'(exp_v));
            if (last_cyc >= 0) check("sweep_interval", 32'(cyc - last_cyc), 32'd10);
            last_cyc = cyc;
            got++;
         end
         if (in_ready8 === 1'b1 && idx < 1024) begin
            x8 = idx[7:0]; sgn8 = idx[8]; mode8 = idx[9]; in_valid8 = 1'b1;
            exp_q.push_back(model(idx[9], idx[7:0], idx[8]));
            idx++;
         end else if (idx >= 1024) begin
            in_valid8 = 1'b0;
         end
      end
      in_valid8 = 1'b0;
      check("sweep_count", 32'(got), 32'd1024);

      // Asynchronous reset with the counter at 3
      @(negedge clk);
      mode8 = 1'b0; x8 = 8'h5A; sgn8 = 1'b1; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      check("rst_mid_busy", 32'(in_ready8), 32'd0);
      repeat (3) @(posedge clk);
      #3 reset_ = 1'b0;
      #1;
      check("rst_mid_in_ready", 32'(in_ready8), 32'd1);
      check("rst_mid_out", {z8, sgn_out8, ow8, out_valid8}, 32'd0);
      @(negedge clk);
      reset_ = 1'b1;
      run8(1'b1, 8'hF6, 1'b0, lat);
      check("post_rst_latency", 32'(lat), 32'd8);
      check("post_rst_f6", {z8, sgn_out8, ow8}, {8'h0A, 1'b1, 1'b0});
      @(posedge clk); #1;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
